// File: rtl/dsp_pkg.sv
// Shared definitions for the down-sample processor and its readout logic.
// No logic here: types and constants only.
// Not applicable: no handshake.
package dsp_pkg;

  // UART 8N1 frame: start bit, eight data bits LSB first, one stop bit.
  localparam int   UART_FRAME_BITS = 10;
  localparam logic UART_START      = 1'b0;
  localparam logic UART_STOP       = 1'b1;

  // Data RAM geometry as seen on its single port.
  localparam int DMEM_AW = 16;
  localparam int DMEM_DW = 8;

  // Dump sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CAPT,
    ST_TXBIT,
    ST_NEXT
  } dump_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART serialiser: baud counter, bit counter and frame shift register.
// Latency: start bit on txd the cycle after load; frame lasts 10*BAUD_DIV cycles.
// Backpressure: tx_busy high while a frame is on the line; load is ignored-safe only when idle.
module uart_tx_core
  import dsp_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DMEM_DW-1:0] byte_in,
  output logic               tx_busy,
  output logic               txd
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(UART_FRAME_BITS - 1);

  logic [UART_FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [15:0]                baud_q, baud_d;
  logic [3:0]                 bit_q, bit_d;
  logic                       active_q, active_d;
  logic                       txd_q, txd_d;
  logic                       baud_tick;
  logic                       frame_end;

  assign baud_tick = active_q && (baud_q == BAUD_LAST);
  assign frame_end = baud_tick && (bit_q == BIT_LAST);
  // Busy drops during the final cycle of the stop bit so the sequencer can
  // step on the same edge that ends the frame, keeping every bit full width.
  assign tx_busy   = active_q && !frame_end;
  assign txd       = txd_q;

  // Next-state: load a fresh frame, or count baud ticks and shift out bits.
  always_comb begin
    shreg_d  = shreg_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (load) begin
      shreg_d  = {UART_STOP, byte_in, UART_START};
      baud_d   = '0;
      bit_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (baud_tick) begin
        baud_d  = '0;
        shreg_d = {UART_STOP, shreg_q[UART_FRAME_BITS-1:1]};
        bit_d   = bit_q + 4'd1;
        if (frame_end) begin
          active_d = 1'b0;
        end
      end else begin
        baud_d = baud_q + 16'd1;
      end
    end
    // Line idles high; otherwise it follows the bit about to be on the wire.
    txd_d = active_d ? shreg_d[0] : UART_STOP;
  end

  // State registers; txd is registered so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      shreg_q  <= shreg_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      active_q <= active_d;
      txd_q    <= txd_d;
    end
  end

endmodule

// File: rtl/ram_dump_uart.sv
// Dumps DUMP_LEN data-RAM bytes from DUMP_BASE out of a UART on a start edge.
// Latency: busy the cycle after the edge; start bit 2 cycles after; 10*BAUD_DIV+3 cycles per byte.
// Backpressure: none upstream; start edges while busy are dropped, not queued.
module ram_dump_uart
  import dsp_pkg::*;
#(
  parameter int unsigned        BAUD_DIV  = 434,
  parameter logic [DMEM_AW-1:0] DUMP_BASE = 16'h0000,
  parameter logic [DMEM_AW-1:0] DUMP_LEN  = 16'h4000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               mem_en,
  output logic [DMEM_AW-1:0] mem_addr,
  input  logic [DMEM_DW-1:0] mem_rdata,
  output logic               txd,
  output logic               busy,
  output logic               done
);

  dump_state_t        state_q, state_d;
  logic [DMEM_AW-1:0] addr_q, addr_d;
  logic [DMEM_AW-1:0] remain_q, remain_d;
  logic               done_q, done_d;
  logic               start_q;
  logic               armed_q;
  logic               launch;
  logic               load;
  logic               tx_busy;

  // armed_q keeps a start level held through reset release from reading as an edge.
  assign launch   = armed_q && start && !start_q;
  assign busy     = (state_q != ST_IDLE);
  assign mem_en   = busy;
  assign mem_addr = addr_q;
  assign done     = done_q;

  uart_tx_core #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .byte_in(mem_rdata),
    .tx_busy(tx_busy),
    .txd    (txd)
  );

  // Sequencer: address a byte, capture it into the UART, wait, advance.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          addr_d   = DUMP_BASE;
          remain_d = DUMP_LEN;
          if (DUMP_LEN == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR:  state_d = ST_CAPT;
      ST_CAPT: begin
        // RAM data for addr_q is valid now, one cycle after ADDR.
        load    = 1'b1;
        state_d = ST_TXBIT;
      end
      ST_TXBIT: begin
        if (!tx_busy) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        addr_d   = addr_q + 16'd1;
        remain_d = remain_q - 16'd1;
        if (remain_q == 16'd1) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ADDR;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers plus the start edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      start_q  <= start;
      armed_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_dump_uart.sv
// Bench for ram_dump_uart: three instances (basic, address wrap, zero length).
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_dump_uart;

  localparam int B = 4;
  localparam int P = 10 * B + 3;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [2:0]  start_r = 3'b111;
  logic [2:0]  txd_w, busy_w, done_w, en_w;
  logic [15:0] addr_w  [3];
  logic [7:0]  rdata_w [3];
  logic [7:0]  ram     [65536];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int phase = 0;
  int last_phase = 0;
  int es0 = 0, es0b = 0, es1 = 0, es2 = 0;

  // model and monitor state, owned by the compare process
  bit          m_act [3];
  int          m_e   [3];
  logic        sprev [3];
  logic        rst_prev = 1'b0;
  int          dcnt  [3];
  int          dlast [3];
  int          busyseen2 = 0;
  bit          rx_on [2];
  int          rx_n0 [2];
  logic [9:0]  rx_sh [2];
  bit          pen   [2];
  logic [15:0] pa    [2];
  logic [15:0] aq0[$], aq1[$];
  logic [7:0]  rx0[$], rx1[$];
  int          n, d, k, off, j;
  logic [15:0] a;
  logic [7:0]  bt;
  logic        et, eb, ed, s_now;

  logic [7:0]  exp_b0 [4] = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
  logic [7:0]  exp_b1 [3] = '{8'h5A, 8'hC3, 8'hA5};
  logic [15:0] exp_a1 [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};

  ram_dump_uart #(.BAUD_DIV(B), .DUMP_BASE(16'h0000), .DUMP_LEN(16'd4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .mem_en(en_w[0]), .mem_addr(addr_w[0]),
    .mem_rdata(rdata_w[0]), .txd(txd_w[0]), .busy(busy_w[0]), .done(done_w[0]));
  ram_dump_uart #(.BAUD_DIV(B), .DUMP_BASE(16'hFFFE), .DUMP_LEN(16'd3)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .mem_en(en_w[1]), .mem_addr(addr_w[1]),
    .mem_rdata(rdata_w[1]), .txd(txd_w[1]), .busy(busy_w[1]), .done(done_w[1]));
  ram_dump_uart #(.BAUD_DIV(B), .DUMP_BASE(16'h0000), .DUMP_LEN(16'd0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .mem_en(en_w[2]), .mem_addr(addr_w[2]),
    .mem_rdata(rdata_w[2]), .txd(txd_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  always #5 clk = ~clk;

  // cycle index: value after edge n is n
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read RAM, one port per instance
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rdata_w[i] <= ram[addr_w[i]];
  end

  function automatic logic [15:0] f_base(input int i);
    return (i == 1) ? 16'hFFFE : 16'h0000;
  endfunction

  function automatic int f_len(input int i);
    case (i)
      0:       return 4;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] qb(input logic [7:0] q[$], input int idx);
    return (idx < q.size()) ? 32'(q[idx]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] qa(input logic [15:0] q[$], input int idx);
    return (idx < q.size()) ? 32'(q[idx]) : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: got %0h, want %0h", nm, idx, cyc, got, want);
    end
  endtask

  // compare process: model every cycle, reset checks, monitors, literal checks
  always @(posedge clk or negedge rst_n) begin
    #1;
    if (clk == 1'b0) begin
      // reset just asserted between clock edges: outputs must already be at reset values
      for (int i = 0; i < 3; i++) begin
        chk("async_rst_txd",  i, 32'(txd_w[i]),  32'd1);
        chk("async_rst_busy", i, 32'(busy_w[i]), 32'd0);
        chk("async_rst_en",   i, 32'(en_w[i]),   32'd0);
        chk("async_rst_done", i, 32'(done_w[i]), 32'd0);
        chk("async_rst_addr", i, 32'(addr_w[i]), 32'd0);
      end
    end else begin
      n = cyc;
      for (int i = 0; i < 3; i++) begin
        s_now = start_r[i];
        if (!rst_n) begin
          m_act[i] = 1'b0;
          chk("rst_txd",  i, 32'(txd_w[i]),  32'd1);
          chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
          chk("rst_en",   i, 32'(en_w[i]),   32'd0);
          chk("rst_done", i, 32'(done_w[i]), 32'd0);
          chk("rst_addr", i, 32'(addr_w[i]), 32'd0);
        end else begin
          // a 0->1 start seen at this edge launches only if out of reset last edge and idle
          if (rst_prev && !sprev[i] && s_now &&
              (!m_act[i] || (n - 1 >= m_e[i] + f_len(i) * P))) begin
            m_act[i] = 1'b1;
            m_e[i]   = n;
          end
          et = 1'b1; eb = 1'b0; ed = 1'b0;
          if (m_act[i]) begin
            d = n - m_e[i];
            if (d < f_len(i) * P) begin
              eb  = 1'b1;
              k   = d / P;
              off = d % P;
              a   = f_base(i) + 16'(k);
              chk("mem_addr", i, 32'(addr_w[i]), 32'(a));
              if (off >= 2 && off < 2 + 10 * B) begin
                j  = (off - 2) / B;
                bt = ram[a];
                if (j == 0)      et = 1'b0;
                else if (j == 9) et = 1'b1;
                else             et = bt[j-1];
              end
            end else if (d == f_len(i) * P) begin
              ed = 1'b1;
            end
          end
          chk("txd",    i, 32'(txd_w[i]),  32'(et));
          chk("busy",   i, 32'(busy_w[i]), 32'(eb));
          chk("mem_en", i, 32'(en_w[i]),   32'(eb));
          chk("done",   i, 32'(done_w[i]), 32'(ed));
          if (done_w[i]) begin
            dcnt[i]++;
            dlast[i] = n;
          end
        end
        sprev[i] = s_now;
      end
      if (rst_n && busy_w[2]) busyseen2++;
      // line decoders and address monitors for the two non-empty dumps
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          rx_on[i] = 1'b0;
          pen[i]   = 1'b0;
        end else begin
          if (!rx_on[i]) begin
            if (txd_w[i] == 1'b0) begin
              rx_on[i] = 1'b1;
              rx_n0[i] = n;
            end
          end else begin
            d = n - rx_n0[i];
            if (d % B == B / 2) begin
              j = d / B;
              rx_sh[i][j] = txd_w[i];
              if (j == 9) begin
                rx_on[i] = 1'b0;
                chk("stop_bit", i, 32'(rx_sh[i][9]), 32'd1);
                if (i == 0) rx0.push_back(rx_sh[i][8:1]);
                else        rx1.push_back(rx_sh[i][8:1]);
              end
            end
          end
          if (en_w[i] && (!pen[i] || addr_w[i] != pa[i])) begin
            if (i == 0) aq0.push_back(addr_w[i]);
            else        aq1.push_back(addr_w[i]);
          end
          pen[i] = en_w[i];
          pa[i]  = addr_w[i];
        end
      end
      rst_prev = rst_n;
      // hand-computed expectations at the end of each scenario
      if (phase != last_phase) begin
        last_phase = phase;
        case (phase)
          1: begin
            chk("idle_txd",  0, 32'(txd_w),  32'h7);
            chk("idle_busy", 0, 32'(busy_w), 32'h0);
            chk("held_start_no_done", 0, 32'(dcnt[0] + dcnt[1] + dcnt[2]), 32'd0);
          end
          2: begin
            chk("basic_addr_cnt", 0, 32'(aq0.size()), 32'd4);
            for (int q = 0; q < 4; q++) chk("basic_addr", q, qa(aq0, q), 32'(q));
            chk("basic_byte_cnt", 0, 32'(rx0.size()), 32'd4);
            for (int q = 0; q < 4; q++) chk("basic_byte", q, qb(rx0, q), 32'(exp_b0[q]));
            chk("basic_done_cnt", 0, 32'(dcnt[0]), 32'd1);
            chk("basic_done_at",  0, 32'(dlast[0] - es0), 32'd172);
          end
          3: begin
            chk("wrap_addr_cnt", 1, 32'(aq1.size()), 32'd3);
            for (int q = 0; q < 3; q++) chk("wrap_addr", q, qa(aq1, q), 32'(exp_a1[q]));
            chk("wrap_byte_cnt", 1, 32'(rx1.size()), 32'd3);
            for (int q = 0; q < 3; q++) chk("wrap_byte", q, qb(rx1, q), 32'(exp_b1[q]));
            chk("wrap_done_cnt", 1, 32'(dcnt[1]), 32'd1);
            chk("wrap_done_at",  1, 32'(dlast[1] - es1), 32'd129);
          end
          4: begin
            chk("zero_done_cnt", 2, 32'(dcnt[2]), 32'd1);
            chk("zero_done_at",  2, 32'(dlast[2] - es2), 32'd0);
            chk("zero_busy_seen", 2, 32'(busyseen2), 32'd0);
            chk("zero_txd", 2, 32'(txd_w[2]), 32'd1);
          end
          5: begin
            chk("retrig_done_cnt", 0, 32'(dcnt[0]), 32'd2);
            chk("retrig_done_at",  0, 32'(dlast[0] - es0b), 32'd172);
            chk("retrig_byte_cnt", 0, 32'(rx0.size()), 32'd8);
            for (int q = 0; q < 4; q++) chk("retrig_byte", q, qb(rx0, 4 + q), 32'(exp_b0[q]));
          end
          6: begin
            chk("abort_done_cnt", 0, 32'(dcnt[0]), 32'd2);
            chk("abort_byte_cnt", 0, 32'(rx0.size()), 32'd9);
            chk("abort_byte0",    0, qb(rx0, 8), 32'hA5);
            chk("abort_busy",     0, 32'(busy_w[0]), 32'd0);
          end
          default: ;
        endcase
      end
    end
  end

  // stimulus
  initial begin
    ram[16'h0000] = 8'hA5;
    ram[16'h0001] = 8'h00;
    ram[16'h0002] = 8'hFF;
    ram[16'h0003] = 8'h3C;
    ram[16'hFFFE] = 8'h5A;
    ram[16'hFFFF] = 8'hC3;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;                      // start held high: must not launch
    repeat (6) @(negedge clk);
    phase = 1;
    repeat (2) @(negedge clk);

    // basic dump of four bytes
    start_r[0] = 1'b0;
    repeat (2) @(negedge clk);
    start_r[0] = 1'b1;
    es0 = cyc + 1;
    repeat (4 * P + 8) @(negedge clk);
    phase = 2;
    repeat (2) @(negedge clk);

    // address wrap FFFE, FFFF, 0000
    start_r[1] = 1'b0;
    repeat (2) @(negedge clk);
    start_r[1] = 1'b1;
    es1 = cyc + 1;
    repeat (3 * P + 8) @(negedge clk);
    phase = 3;
    repeat (2) @(negedge clk);

    // zero length
    start_r[2] = 1'b0;
    repeat (2) @(negedge clk);
    start_r[2] = 1'b1;
    es2 = cyc + 1;
    repeat (6) @(negedge clk);
    phase = 4;
    repeat (2) @(negedge clk);

    // re-trigger attempts during a dump
    start_r[0] = 1'b0;
    repeat (2) @(negedge clk);
    start_r[0] = 1'b1;
    es0b = cyc + 1;
    repeat (60) @(negedge clk);
    start_r[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_r[0] = 1'b1;
    repeat (3) @(negedge clk);
    start_r[0] = 1'b0;
    repeat (3) @(negedge clk);
    start_r[0] = 1'b1;
    repeat (4 * P - 69 + 8) @(negedge clk);
    phase = 5;
    repeat (2) @(negedge clk);

    // abort with reset during the data bits of the second byte
    start_r[0] = 1'b0;
    repeat (2) @(negedge clk);
    start_r[0] = 1'b1;
    repeat (P + 13) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    phase = 6;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
